// File: rtl/servo_pwm_out.sv
// Three-channel servo PWM generator with frame-synchronous double-buffered widths,
// range clamping and optional per-frame slew limiting (enable with SERVO_PWM_SLEW_EN).
module servo_pwm_out #(
  parameter int unsigned PERIOD    = 1_000_000,
  parameter int unsigned MIN_PULSE = 25_000,
  parameter int unsigned MAX_PULSE = 125_000,
  parameter int unsigned SLEW_STEP = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pwm1,
  input  logic [31:0] pwm2,
  input  logic [31:0] catch_pwm,
  output logic        servo1,
  output logic        servo2,
  output logic        servo3,
  output logic        frame_tick,
  output logic [2:0]  sat
);

  localparam logic [31:0] LAST_CNT = 32'(PERIOD - 1);
  localparam logic [31:0] MIN_W    = 32'(MIN_PULSE);
  localparam logic [31:0] MAX_W    = 32'(MAX_PULSE);
`ifdef SERVO_PWM_SLEW_EN
  localparam logic [31:0] STEP_W   = 32'(SLEW_STEP);
`endif

  logic [31:0]       cnt_q, cnt_d;
  logic [2:0][31:0]  w_q, w_d;
  logic [2:0][31:0]  tgt;
  logic [2:0][31:0]  req;
  logic [2:0]        sat_q, sat_d;
  logic [2:0]        clamp;
  logic [2:0]        servo_q, servo_d;
  logic              tick_q, tick_d;
  logic              latch;

  assign req[0] = pwm1;
  assign req[1] = pwm2;
  assign req[2] = catch_pwm;

  assign latch = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = latch ? 32'd0 : cnt_q + 32'd1;
  end

  // Clamp each request into the safe servo range; zero passes through as "off".
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      tgt[k]   = req[k];
      clamp[k] = 1'b0;
      if (req[k] == 32'd0) begin
        tgt[k] = 32'd0;
      end else if (req[k] < MIN_W) begin
        tgt[k]   = MIN_W;
        clamp[k] = 1'b1;
      end else if (req[k] > MAX_W) begin
        tgt[k]   = MAX_W;
        clamp[k] = 1'b1;
      end
    end
  end

  always_comb begin
    w_d   = w_q;
    sat_d = sat_q;
    if (latch) begin
      sat_d = clamp;
      for (int k = 0; k < 3; k++) begin
`ifdef SERVO_PWM_SLEW_EN
        // On/off transitions jump; otherwise move at most one step toward target.
        if (tgt[k] == 32'd0 || w_q[k] == 32'd0) begin
          w_d[k] = tgt[k];
        end else if (tgt[k] > w_q[k]) begin
          w_d[k] = ((tgt[k] - w_q[k]) > STEP_W) ? w_q[k] + STEP_W : tgt[k];
        end else if (tgt[k] < w_q[k]) begin
          w_d[k] = ((w_q[k] - tgt[k]) > STEP_W) ? w_q[k] - STEP_W : tgt[k];
        end else begin
          w_d[k] = w_q[k];
        end
`else
        w_d[k] = tgt[k];
`endif
      end
    end
  end

  // Pins are computed from next-state values so the flop matches cnt < w each cycle.
  always_comb begin
    tick_d = latch;
    for (int k = 0; k < 3; k++) begin
      servo_d[k] = (cnt_d < w_d[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 32'd0;
      w_q     <= '0;
      sat_q   <= 3'b000;
      servo_q <= 3'b000;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      sat_q   <= sat_d;
      servo_q <= servo_d;
      tick_q  <= tick_d;
    end
  end

  assign servo1     = servo_q[0];
  assign servo2     = servo_q[1];
  assign servo3     = servo_q[2];
  assign frame_tick = tick_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_servo_pwm_out.sv
// Bench for servo_pwm_out: directed scenarios plus random widths, checked each cycle
// against a frame-level reference model (position in frame vs. latched width).
module tb_servo_pwm_out;

  localparam int unsigned PERIOD    = 100;
  localparam int unsigned MIN_PULSE = 5;
  localparam int unsigned MAX_PULSE = 20;
  localparam int unsigned SLEW_STEP = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pwm1 = 32'd0;
  logic [31:0] pwm2 = 32'd0;
  logic [31:0] catch_pwm = 32'd0;
  logic        servo1, servo2, servo3, frame_tick;
  logic [2:0]  sat;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: position within the frame and the width used per frame.
  int unsigned phase = 0;
  int unsigned mw [3] = '{0, 0, 0};
  logic [2:0]  msat = 3'b000;
  bit          latched = 0;

  servo_pwm_out #(
    .PERIOD(PERIOD), .MIN_PULSE(MIN_PULSE), .MAX_PULSE(MAX_PULSE), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwm1(pwm1), .pwm2(pwm2), .catch_pwm(catch_pwm),
    .servo1(servo1), .servo2(servo2), .servo3(servo3),
    .frame_tick(frame_tick), .sat(sat)
  );

  always #5 clk = ~clk;

  function automatic int unsigned target_of(input logic [31:0] x);
    if (x == 0) return 0;
    if (x < MIN_PULSE) return MIN_PULSE;
    if (x > MAX_PULSE) return MAX_PULSE;
    return int'(x);
  endfunction

  function automatic bit clamped(input logic [31:0] x);
    return (x != 0) && (x < MIN_PULSE || x > MAX_PULSE);
  endfunction

  function automatic int unsigned next_width(input int unsigned w, input int unsigned t);
`ifdef SERVO_PWM_SLEW_EN
    if (t == 0 || w == 0) return t;
    if (t > w) return (t - w > SLEW_STEP) ? w + SLEW_STEP : t;
    if (t < w) return (w - t > SLEW_STEP) ? w - SLEW_STEP : t;
    return w;
`else
    return t;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("servo1", {31'd0, servo1}, {31'd0, phase < mw[0]});
    check("servo2", {31'd0, servo2}, {31'd0, phase < mw[1]});
    check("servo3", {31'd0, servo3}, {31'd0, phase < mw[2]});
    check("frame_tick", {31'd0, frame_tick}, {31'd0, (phase == 0) && latched});
    check("sat", {29'd0, sat}, {29'd0, msat});
  endtask

  // One clock: the model latches inputs at the end of a frame, then outputs are checked.
  task automatic tick();
    logic [31:0] req [3];
    req[0] = pwm1; req[1] = pwm2; req[2] = catch_pwm;
    @(posedge clk);
    if (phase == PERIOD - 1) begin
      for (int k = 0; k < 3; k++) begin
        mw[k]   = next_width(mw[k], target_of(req[k]));
        msat[k] = clamped(req[k]);
      end
      latched = 1;
    end
    phase = (phase + 1) % PERIOD;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    phase = 0; mw = '{0, 0, 0}; msat = 3'b000; latched = 0;
  endtask

  initial begin
    // Reset state and release on a falling edge.
    #1;
    check("rst_servo1", {31'd0, servo1}, 32'd0);
    check("rst_tick", {31'd0, frame_tick}, 32'd0);
    check("rst_sat", {29'd0, sat}, 32'd0);
    @(negedge clk);
    pwm1 = 32'd10;
    rst_n = 1'b1;
    model_reset();
    #1;
    check_outputs();

    // Basic: blank first frame, then 10-cycle pulses.
    run(350);

    // Clamp low/high, then clear saturation with in-range values.
    pwm2 = 32'd2; catch_pwm = 32'd500;
    run(200);
    check("clamp_sat", {29'd0, sat}, 32'b110);
    pwm2 = 32'd10; catch_pwm = 32'd10;
    run(200);
    check("clamp_clear", {29'd0, sat}, 32'b000);

    // Off channel, then a mid-frame change only takes effect next frame.
    pwm1 = 32'd0;
    run(200);
    pwm1 = 32'd10;
    for (int i = 0; i < 400 && !(phase == 50 && mw[0] == 10); i++) tick();
    check("reach_mid", {31'd0, phase == 50 && mw[0] == 10}, 32'd1);
    pwm1 = 32'd15;
    run(250);

    // Async reset in the middle of a pulse.
    pwm1 = 32'd10;
    for (int i = 0; i < 400 && !(phase == 3 && mw[0] == 10); i++) tick();
    check("reach_pulse", {31'd0, servo1}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_servo1", {31'd0, servo1}, 32'd0);
    check("async_sat", {29'd0, sat}, 32'd0);
    check("async_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_outputs();
    run(250);

    // Slew-sensitive sequence (step limited only when the feature is built in).
    pwm1 = 32'd6;
    run(300);
    pwm1 = 32'd18;
    run(600);
    pwm1 = 32'd0;
    run(200);

    // Randomized widths changed at random points in the frame.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] v;
        case ($urandom_range(0, 3))
          0: v = 32'd0;
          1: v = 32'($urandom_range(1, 30));
          2: v = $urandom;
          default: v = 32'($urandom_range(MIN_PULSE, MAX_PULSE));
        endcase
        if (k == 0) pwm1 = v; else if (k == 1) pwm2 = v; else catch_pwm = v;
      end
      run($urandom_range(10, 250));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/servo_pwm_out.md
# servo_pwm_out

Three-channel servo PWM generator for the arm controller. Consumes the 32-bit pulse-width words produced by the arm motion logic (`pwm1`, `pwm2`, `catch_pwm`) and drives three servo pins with one fixed-period frame. Width words are double-buffered and latched only at frame boundaries, so a pulse is never cut short or stretched mid-frame. Widths are clamped to a safe servo range, and optional slew limiting is available.

## Interface
- `PERIOD`, 1_000_000: frame length in clk cycles (20 ms at 50 MHz); must be > `MAX_PULSE`.
- `MIN_PULSE`, 25_000: minimum nonzero high time in cycles (0.5 ms); must be ≥ 1.
- `MAX_PULSE`, 125_000: maximum high time in cycles (2.5 ms).
- `SLEW_STEP`, 500: maximum width change per frame, in cycles (used only with `SERVO_PWM_SLEW_EN`); must be ≥ 1.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pwm1` in 32: channel 1 target width in cycles, unsigned; 0 means channel off.
- `pwm2` in 32: channel 2 target width, same encoding.
- `catch_pwm` in 32: gripper (channel 3) target width, same encoding.
- `servo1` out 1: channel 1 pulse output, registered.
- `servo2` out 1: channel 2 pulse output, registered.
- `servo3` out 1: gripper pulse output, registered.
- `frame_tick` out 1: one-cycle pulse in the first cycle of each frame.
- `sat` out 3: per-channel flag (bit0 = ch1), set if the last latched target was clamped.

## Operation
- Frame counter `cnt` (32 bit) counts 0..`PERIOD`-1 and wraps to 0.
- **Latch edge:** the clock edge where `cnt == PERIOD-1`. Inputs are sampled only on this edge. Input changes at any other time have no effect until the next latch edge.
- **Target per channel:**
  - input 0 → t = 0;
  - input < `MIN_PULSE` → t = `MIN_PULSE` and the `sat` bit is set;
  - input > `MAX_PULSE` → t = `MAX_PULSE` and the `sat` bit is set;
  - otherwise t = input and the `sat` bit is cleared.
  - `sat` updates only at the latch edge.
- **Active width** `w` is updated at the latch edge: `w <= t`, or the slew rule below when it is compiled in.
- **Output:** `servo_k` is high in exactly the cycles where `cnt < w_k`. A channel with `w = 0` stays low for the whole frame.
- **Arithmetic:** all values are unsigned 32-bit. Clamped values are ≤ `MAX_PULSE`, so there is no overflow.
- **Reset (asynchronous, immediate, including mid-frame):**
  - `cnt = 0`, all `w = 0`;
  - `servo1`, `servo2`, `servo3` = 0;
  - `frame_tick = 0`, `sat = 3'b000`.

## Timing
- All outputs are flops. There is no combinational path from inputs to outputs.
- `servo_k` is generated registered from next-state values, so `servo_k == (cnt < w_k)` holds in every cycle.
- First cycle after reset release: `cnt = 0`, `frame_tick = 0`, outputs low. Frame 0 is blank on all channels.
- First latch edge is `PERIOD`-1 edges after reset release. The first pulse starts in cycle `PERIOD` after release.
- `frame_tick` is high in the cycle where `cnt == 0` following each latch edge. Its period is exactly `PERIOD` cycles.
- Input-to-pin latency is 0 to `PERIOD` cycles after the next latch edge, depending on arrival time within the frame.
- The rising edge of every nonzero channel coincides with the cycle in which `frame_tick` is high.

## Configuration
- **`SERVO_PWM_SLEW_EN` defined:** at the latch edge, each channel updates as follows.
  - If t = 0 or w = 0: `w <= t` (on/off transitions jump immediately).
  - Else if t > w: `w <= w + min(SLEW_STEP, t-w)`.
  - Else if t < w: `w <= w - min(SLEW_STEP, w-t)`.
  - Else w is unchanged.
- **Not defined:** `w <= t` on every latch edge. The `SLEW_STEP` parameter is unused.
- `sat` behaviour is identical in both builds.

## Test plan
All scenarios use `PERIOD=100`, `MIN_PULSE=5`, `MAX_PULSE=20`, `SLEW_STEP=3`.
- **Basic:** reset, then `pwm1=10` held.
  - Cycles 0–99: `servo1` low.
  - Then `servo1` high for 10 cycles and low for 90, repeating.
  - `frame_tick` high once per 100 cycles, aligned with the `servo1` rise.
- **Clamp:** `pwm2=2`, `catch_pwm=500`.
  - `servo2` high 5 cycles and `servo3` high 20 cycles per frame.
  - `sat=3'b110` after the first latch edge.
  - Setting both inputs to 10 clears `sat` at the next latch edge.
- **Off and mid-frame change:**
  - `pwm1=0` gives no pulse.
  - Changing `pwm1` from 10 to 15 at `cnt=50` leaves the current frame at 10; the next frame is 15.
- **Async reset mid-pulse:** assert `rst_n=0` at `cnt=3` with `w=10`.
  - `servo1` falls without waiting for a clock edge.
  - After release, the frame is blank and the pulse resumes in cycle 100.
- **Slew (`SERVO_PWM_SLEW_EN`):** `pwm1=6` for several frames, then `pwm1=18`.
  - Successive frame widths are 9, 12, 15, 18, 18.
  - Then `pwm1=0`: the next frame has width 0.
  - Without the macro the same sequence gives widths 18, then 0.
